// File: rtl/mux_rr_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mux_rr_pkg                                                           |
// | Shared constants, types and helpers for the round-robin mux.         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package mux_rr_pkg;

    localparam int CNT_W = 16;

    // Channel index width; a single channel still gets one bit.
    function automatic int ch_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_e;

endpackage
`default_nettype wire

// File: rtl/rr_arb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_arb                                                               |
// | Combinational round-robin arbiter: first request at or after ptr.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module rr_arb #(
    parameter int N_CH = 4,
    parameter int CH_W = 2
) (
    input  logic [N_CH-1:0] req,
    input  logic [CH_W-1:0] ptr,
    output logic [N_CH-1:0] grant,
    output logic [CH_W-1:0] grant_idx,
    output logic            grant_valid
);

    int cand;

    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        cand        = 0;
        for (int off = 0; off < N_CH; off++) begin
            cand = (int'(ptr) + off) % N_CH;
            if (!grant_valid && req[cand]) begin
                grant_valid = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = CH_W'(cand);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mux_rr_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mux_rr_pipe                                                          |
// | N-channel round-robin mux with one registered valid/ready stage.     |
// | Define MUX_RR_CNT_EN to add per-channel saturating accept counters.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module mux_rr_pipe
    import mux_rr_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int WIDTH = 8,
    localparam int CH_W = ch_w(N_CH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_CH-1:0]         in_valid,
    input  logic [N_CH*WIDTH-1:0]   in_data,
    output logic [N_CH-1:0]         in_ready,
    output logic                    out_valid,
    output logic [WIDTH-1:0]        out_data,
    output logic [CH_W-1:0]         out_ch,
    input  logic                    out_ready
`ifdef MUX_RR_CNT_EN
    ,
    output logic [N_CH*CNT_W-1:0]   cnt
`endif
);

    out_state_e         state_q, state_d;
    logic [WIDTH-1:0]   data_q,  data_d;
    logic [CH_W-1:0]    ch_q,    ch_d;
    logic [CH_W-1:0]    ptr_q,   ptr_d;

    logic [N_CH-1:0]    grant;
    logic [CH_W-1:0]    gnt_idx;
    logic               gnt_any;
    logic               load;
    logic               accept;

    rr_arb #(
        .N_CH (N_CH),
        .CH_W (CH_W)
    ) u_arb (
        .req         (in_valid),
        .ptr         (ptr_q),
        .grant       (grant),
        .grant_idx   (gnt_idx),
        .grant_valid (gnt_any)
    );

    // Register is free if empty or being drained by the sink this cycle.
    assign load     = (state_q == ST_EMPTY) || out_ready;
    assign in_ready = grant & {N_CH{load}};
    assign accept   = gnt_any && load;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        ch_d    = ch_q;
        ptr_d   = ptr_q;
        if (accept) begin
            state_d = ST_FULL;
            data_d  = in_data[int'(gnt_idx)*WIDTH +: WIDTH];
            ch_d    = gnt_idx;
            ptr_d   = (gnt_idx == CH_W'(N_CH-1)) ? '0 : gnt_idx + 1'b1;
        end else if (out_ready) begin
            state_d = ST_EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            data_q  <= '0;
            ch_q    <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            ch_q    <= ch_d;
            ptr_q   <= ptr_d;
        end
    end

    assign out_valid = (state_q == ST_FULL);
    assign out_data  = data_q;
    assign out_ch    = ch_q;

`ifdef MUX_RR_CNT_EN
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_cnt
        logic [CNT_W-1:0] cnt_q, cnt_d;

        always_comb begin
            cnt_d = cnt_q;
            if (accept && grant[gi] && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        assign cnt[gi*CNT_W +: CNT_W] = cnt_q;
    end
`endif

endmodule
`default_nettype wire

// File: doc/mux_rr_pipe.md
# mux_rr_pipe

Parametrised N-channel, WIDTH-bit registered multiplexer that selects among valid sources with a round-robin arbiter and presents the winner through one output register stage with valid/ready flow control. It supersedes the fixed 2:1 combinational select logic wherever several producers share one downstream consumer. It sits between per-channel producers and a single sink, sustaining one transfer per cycle.

## Interface
- N_CH, 4, number of input channels (≥1)
- WIDTH, 8, data width in bits (≥1)
- clk  in  1  rising-edge clock
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- in_valid  in  N_CH  per-channel request
- in_data  in  N_CH×WIDTH  per-channel payload
- in_ready  out  N_CH  per-channel accept (at most one bit high per cycle)
- out_valid  out  1  output register holds a word
- out_data  out  WIDTH  registered payload
- out_ch  out  CH_W  index of channel that supplied out_data; CH_W = max(1, $clog2(N_CH))
- out_ready  in  1  sink accepts out_data this cycle

## Operation
- Internal state: out_valid (EMPTY/FULL), out_data, out_ch, round-robin pointer ptr (CH_W bits).
- load = !out_valid || out_ready (register free or draining this cycle).
- Grant: first i with in_valid[i]=1 searching ptr, ptr+1, … N_CH-1, 0, … ptr-1; at most one grant.
- in_ready[i] = grant[i] && load; combinational from in_valid, ptr, out_valid, out_ready; no path from in_data.
- Accept (in_valid[i] && in_ready[i]): next cycle out_data=in_data[i], out_ch=i, out_valid=1, ptr = (i+1) mod N_CH.
- EMPTY→FULL on accept; FULL→FULL on out_ready with accept (back-to-back); FULL→EMPTY on out_ready without accept; FULL held while !out_ready (out_data/out_ch stable).
- No requests: no grant, ptr unchanged, all in_ready=0.
- ptr advances only on accept; wraps N_CH-1→0.
- Sources keep in_valid/in_data stable until accepted; grant may move to another channel across stall cycles as other requests arrive, but ptr does not move during stalls.
- N_CH=1: ptr constant 0, block is a pipeline register stage with handshake.

## Timing
- Reset (asynchronous assert, synchronous-release use): out_valid=0, out_data=0, out_ch=0, ptr=0, in_ready follows combinationally (high for lowest valid channel once reset deasserts).
- Latency: accept at edge k → out_valid/out_data valid after edge k.
- Throughput: 1 word/cycle with out_ready held high.
- Reset mid-operation: out_valid drops immediately; held word is discarded; ptr returns to 0.
- Fairness: with all channels requesting continuously, each channel is granted exactly once every N_CH accepts.

## Configuration
- MUX_RR_CNT_EN defined: adds output port cnt, N_CH×16, per-channel saturating accept counter (reset 0, +1 per accept on that channel, sticks at 16'hFFFF).
- Not defined: port and counters absent; all other behaviour identical.

## Structure
- Package mux_rr_pkg: CNT_W=16 constant, function ch_w(n) returning max(1, $clog2(n)), typedef for the EMPTY/FULL state enum.
- Sub-module rr_arb: inputs req[N_CH], ptr; output one-hot grant[N_CH] and encoded grant index; purely combinational, reusable by later arbiters.
- Top holds output register, pointer, handshake, optional counters.

## Test plan
- Reset: drive rst_n=0 mid-transfer with out_valid=1 → out_valid=0, out_data=0, out_ch=0 immediately; first grant after release goes to channel 0 if all request.
- All 4 channels valid, out_ready=1, data=ch×16'h11 → out_ch sequence 0,1,2,3,0,… one per cycle, out_data matches.
- Only channel 2 valid continuously → granted every cycle, ptr stays 3 after each accept, out_ch=2 each cycle.
- out_ready=0 for 3 cycles with out_valid=1 → out_data/out_ch stable, all in_ready=0; on out_ready=1 next word loads same edge.
- ptr=3, requests on channels 1 and 3 → channel 3 granted, then wrap ptr=0, channel 1 granted next.
- MUX_RR_CNT_EN: 70000 accepts on channel 0 → cnt[0]=16'hFFFF, other counters 0.
